fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Arbiter and sequencer for the single-port block frame-buffer BRAM behind the VGA block display. It shares the one BRAM port between the display scan-out (read requester, highest priority) and the pixel FIFO loader (write requester). It also sequences the buffer through clear, fill and hold phases: clear on reset or `start_over`, fill from the FIFO, then hold the completed frame for display only.

## Interface
Parameters:
- `DEPTH`, 768: number of block entries (`BLOCKS_WIDE*BLOCKS_HIGH`).
- `ADDR_W`, 10: BRAM address width; `DEPTH <= 2**ADDR_W`.
- `DATA_W`, 8: pixel/RGB width.
- `CLEAR_COLOR`, 8'h00: value written during clear and returned for out-of-range reads.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_over`  in  1  level; while high, hold in CLEAR at pointer 0; clearing restarts on deassert.
- `fifo_empty`  in  1  pixel FIFO empty (first-word-fall-through).
- `fifo_dout`  in  DATA_W  FIFO head word, valid while `!fifo_empty`.
- `fifo_rd_en`  out  1  pop; high only in the cycle the head word is written.
- `disp_req`  in  1  display read request this cycle.
- `disp_addr`  in  ADDR_W  display read address.
- `disp_valid`  out  1  read data valid (one cycle after request).
- `disp_data`  out  DATA_W  read data.
- `bram_addr`  out  ADDR_W  BRAM address.
- `bram_din`  out  DATA_W  BRAM write data.
- `bram_we`  out  1  BRAM write enable.
- `bram_dout`  in  DATA_W  BRAM read data, 1-cycle latency.
- `busy`  out  1  clear in progress (state CLEAR, or `rst` high).
- `frame_done`  out  1  state FULL.
- `fill_count`  out  ADDR_W+1  entries written in the current FILL.

## Operation
- States: CLEAR, FILL, FULL. Registered `ptr` is ADDR_W+1 bits.
- Reset: state CLEAR, `ptr`=0, `fill_count`=0, `disp_valid`=0. While `rst` is high, `bram_we`=0, `fifo_rd_en`=0 and `busy`=1.
- `start_over` high, any state: next state CLEAR, `ptr`=0, `fill_count`=0. No writes while it is high. Display reads are still served.
- Grant: `disp_req` always wins the port. `bram_addr`=`disp_addr`, `bram_we`=0. A write pending that cycle is stalled; no FIFO pop and no `ptr` change.
- CLEAR, no `disp_req`: `bram_we`=1, `bram_addr`=`ptr`, `bram_din`=CLEAR_COLOR, `ptr`++. The write to DEPTH-1 moves to FILL with `ptr`=0.
- FILL, no `disp_req`, `!fifo_empty`: `bram_we`=1, `bram_din`=`fifo_dout`, `fifo_rd_en`=1, `ptr`++, `fill_count`++. The write to DEPTH-1 moves to FULL.
- FILL, `fifo_empty`: idle; no pop.
- FULL: `fifo_rd_en` is held 0 and data stays in the FIFO. Only display reads occur.
- Out-of-range read (`disp_addr >= DEPTH`): no BRAM access. The read still returns `disp_valid` next cycle with `disp_data`=CLEAR_COLOR. The port is free that cycle, so a pending write proceeds.
- `disp_data` = CLEAR_COLOR for a registered out-of-range flag, else `bram_dout`.
- `bram_addr`, `bram_din`, `bram_we` and `fifo_rd_en` are combinational from state, `ptr` and inputs.
- `disp_valid`, `frame_done` and `busy` derive from registers, except that `busy` is forced high during `rst`.

## Timing
- Read latency: `disp_req` sampled at edge N gives `disp_valid`=1 with data in cycle N+1. Back-to-back requests give one result per cycle.
- Write: takes effect at the edge ending the granted cycle. The FIFO pops at the same edge.
- Clear duration: exactly DEPTH write cycles plus stalled cycles. `busy` falls the cycle after the DEPTH-1 write.
- `frame_done` rises the cycle after the DEPTH-1 fill write. It stays high until `rst` or `start_over`.
- A read of an address in the same cycle as its write cannot occur, because reads preempt writes.
- A read of a just-written address in the following cycle returns the new data.

## Test plan
- Reset, DEPTH=16, no requests: `busy`=1 for 16 cycles with `bram_we`=1 at addrs 0..15 and `bram_din`=8'h00. Then `busy`=0 and the state is FILL.
- FIFO preloaded with 16 words 0x10..0x1F: 16 pops, writes 0..15, `fill_count`=16. `frame_done`=1 next cycle; a 17th FIFO word is not popped.
- `disp_req` alternating every cycle during FILL: every request gets `disp_valid` next cycle. Writes occur only in idle cycles; the final buffer equals 0x10..0x1F in order.
- Read addr 5 after FULL returns 0x15 next cycle. Read addr 20 (≥DEPTH) returns CLEAR_COLOR with `bram_we` allowed that cycle.
- `start_over` pulsed 3 cycles mid-FILL at `fill_count`=7: no writes while high. Then a full 16-cycle clear, `fill_count`=0, and a new fill from addr 0.
- `rst` asserted mid-clear at `ptr`=9: outputs quiet for that cycle, then clear restarts at addr 0.

Source files
------------

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer BRAM arbiter: display reads always preempt the
// clear/fill write sequencer, which walks CLEAR -> FILL -> FULL.
module fb_arbiter #(
  parameter int                 DEPTH       = 768,
  parameter int                 ADDR_W      = 10,
  parameter int                 DATA_W      = 8,
  parameter logic [DATA_W-1:0]  CLEAR_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_over,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   fill_count
);

  typedef enum logic [1:0] {CLEAR, FILL, FULL} state_t;

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_P  = (ADDR_W+1)'(DEPTH - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [ADDR_W:0] r_ptr;
  logic [ADDR_W:0] w_ptr_next;
  logic [ADDR_W:0] r_fill_count;
  logic [ADDR_W:0] w_fill_count_next;
  logic            r_disp_valid;
  logic            r_oor;

  logic w_in_range;
  logic w_rd_grant;
  logic w_wr_ok;
  logic w_clear_wr;
  logic w_fill_wr;
  logic w_last;

  // Out-of-range reads never touch the BRAM, so they leave the port to the writer.
  assign w_in_range = ({1'b0, disp_addr} < DEPTH_P);
  assign w_rd_grant = disp_req & w_in_range;
  assign w_wr_ok    = !rst & !start_over & !w_rd_grant;
  assign w_clear_wr = w_wr_ok & (r_state == CLEAR);
  assign w_fill_wr  = w_wr_ok & (r_state == FILL) & !fifo_empty;
  assign w_last     = (r_ptr == LAST_P);

  always_comb begin
    w_state_next      = r_state;
    w_ptr_next        = r_ptr;
    w_fill_count_next = r_fill_count;
    bram_we           = 1'b0;
    fifo_rd_en        = 1'b0;
    bram_addr         = r_ptr[ADDR_W-1:0];
    bram_din          = (r_state == CLEAR) ? CLEAR_COLOR : fifo_dout;

    if (w_rd_grant) begin
      bram_addr = disp_addr;
    end

    if (start_over) begin
      w_state_next      = CLEAR;
      w_ptr_next        = '0;
      w_fill_count_next = '0;
    end else if (w_clear_wr) begin
      bram_we = 1'b1;
      if (w_last) begin
        w_state_next      = FILL;
        w_ptr_next        = '0;
        w_fill_count_next = '0;
      end else begin
        w_ptr_next = r_ptr + 1'b1;
      end
    end else if (w_fill_wr) begin
      bram_we           = 1'b1;
      fifo_rd_en        = 1'b1;
      w_ptr_next        = r_ptr + 1'b1;
      w_fill_count_next = r_fill_count + 1'b1;
      if (w_last) begin
        w_state_next = FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= CLEAR;
      r_ptr        <= '0;
      r_fill_count <= '0;
      r_disp_valid <= 1'b0;
      r_oor        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_fill_count <= w_fill_count_next;
      r_disp_valid <= disp_req;
      r_oor        <= disp_req & !w_in_range;
    end
  end

  assign disp_valid = r_disp_valid;
  assign disp_data  = r_oor ? CLEAR_COLOR : bram_dout;
  assign busy       = rst | (r_state == CLEAR);
  assign frame_done = (r_state == FULL);
  assign fill_count = r_fill_count;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with DEPTH=16: behavioural BRAM and FIFO
// models around the DUT, one task per scenario.
module tb_fb_arbiter;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_over;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [DATA_W-1:0] bram_dout;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W:0]   fill_count;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] fq [$];
  logic [DATA_W-1:0] pop_tmp;

  // Values seen just before the active edge of the last cycle
  logic              s_we, s_rd, s_busy;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  fb_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_COLOR(8'h00)) dut (
    .clk(clk), .rst(rst), .start_over(start_over),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_dout(bram_dout),
    .busy(busy), .frame_done(frame_done), .fill_count(fill_count)
  );

  // One clock cycle: drive at negedge, sample combinational outputs, return at next negedge.
  task automatic cycle(input logic req, input logic [ADDR_W-1:0] addr);
    disp_req   = req;
    disp_addr  = addr;
    fifo_empty = (fq.size() == 0);
    fifo_dout  = fifo_empty ? 8'h00 : fq[0];
    #1;
    s_we = bram_we; s_rd = fifo_rd_en; s_busy = busy; s_addr = bram_addr; s_din = bram_din;
    if (fifo_rd_en && fq.size() > 0) pop_tmp = fq.pop_front();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_over = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, '0);
      total++;
      if ({s_we, s_rd, s_busy} !== 3'b001) begin
        bad++; $display("FAIL reset_outputs: we/rd/busy=%b required 001", {s_we, s_rd, s_busy});
      end
    end
    total++;
    if ({disp_valid, frame_done, fill_count} !== {2'b00, 6'd0}) begin
      bad++; $display("FAIL reset_regs: valid=%b done=%b fill=%0d required 0 0 0", disp_valid, frame_done, fill_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0);
      total++;
      if ({s_we, s_rd, s_busy, s_addr, s_din} !== {3'b101, 5'(i), 8'h00}) begin
        bad++; $display("FAIL clear_write %0d: we=%b rd=%b busy=%b addr=%0d din=%h required 1 0 1 %0d 00",
                        i, s_we, s_rd, s_busy, s_addr, s_din, i);
      end
    end
    total++;
    if ({busy, frame_done} !== 2'b00) begin
      bad++; $display("FAIL clear_end: busy=%b done=%b required 0 0", busy, frame_done);
    end
    $display("clear done: busy=%b", busy);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0);
      total++;
      if ({s_we, s_rd, s_addr, s_din} !== {2'b11, 5'(i), 8'(8'h10 + i)}) begin
        bad++; $display("FAIL fill_write %0d: we=%b rd=%b addr=%0d din=%h required 1 1 %0d %h",
                        i, s_we, s_rd, s_addr, s_din, i, 8'(8'h10 + i));
      end
      total++;
      if (fill_count !== 6'(i + 1)) begin
        bad++; $display("FAIL fill_count %0d: got %0d required %0d", i, fill_count, i + 1);
      end
    end
    total++;
    if (frame_done !== 1'b1) begin
      bad++; $display("FAIL frame_done: got %b required 1", frame_done);
    end
    cycle(1'b0, '0);
    total++;
    if ({s_we, s_rd} !== 2'b00 || fq.size() != 1) begin
      bad++; $display("FAIL full_no_pop: we=%b rd=%b fifo_left=%0d required 0 0 1", s_we, s_rd, fq.size());
    end
    $display("fill done: fill_count=%0d frame_done=%b", fill_count, frame_done);
  endtask

  task automatic test_read();
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 5'(k + 3);                   // back-to-back reads of 3,4,5
      cycle(1'b1, a);
      total++;
      if ({s_we, s_addr, disp_valid, disp_data} !== {1'b0, a, 1'b1, 8'(8'h10 + k + 3)}) begin
        bad++; $display("FAIL read_full addr %0d: we=%b baddr=%0d valid=%b data=%h required 0 %0d 1 %h",
                        a, s_we, s_addr, disp_valid, disp_data, a, 8'(8'h10 + k + 3));
      end
    end
    cycle(1'b1, 5'd20);
    total++;
    if ({disp_valid, disp_data} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL read_oor: valid=%b data=%h required 1 00", disp_valid, disp_data);
    end
    cycle(1'b0, '0);
    total++;
    if (disp_valid !== 1'b0) begin
      bad++; $display("FAIL valid_idle: got %b required 0", disp_valid);
    end
    $display("reads done");
  endtask

  task automatic pulse_start_over(input int n);
    start_over = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, '0);
      total++;
      if ({s_we, s_rd, busy, fill_count} !== {3'b001, 6'd0}) begin
        bad++; $display("FAIL start_over_hold %0d: we=%b rd=%b busy=%b fill=%0d required 0 0 1 0",
                        i, s_we, s_rd, busy, fill_count);
      end
    end
    start_over = 1'b0;
  endtask

  task automatic test_fill_interleaved();
    int wc = 0;
    int k  = 0;
    logic              req;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp_d;
    fq.delete();
    pulse_start_over(1);
    test_clear();
    for (int i = 0; i < DEPTH; i++) fq.push_back(8'(8'h10 + i));
    while (wc < DEPTH && k < 60) begin
      req = k[0];
      a   = (k == 5) ? 5'd20 : 5'((k >> 1) & 15);
      cycle(req, a);
      if (req && a < DEPTH) begin
        exp_d = (a < wc) ? 8'(8'h10 + a) : 8'h00;
        total++;
        if ({s_we, s_addr, disp_valid, disp_data} !== {1'b0, a, 1'b1, exp_d}) begin
          bad++; $display("FAIL interleave_read k=%0d: we=%b baddr=%0d valid=%b data=%h required 0 %0d 1 %h",
                          k, s_we, s_addr, disp_valid, disp_data, a, exp_d);
        end
      end else begin
        total++;
        if ({s_we, s_rd, s_addr, s_din, disp_valid} !== {2'b11, 5'(wc), 8'(8'h10 + wc), req}) begin
          bad++; $display("FAIL interleave_write k=%0d: we=%b rd=%b addr=%0d din=%h valid=%b required 1 1 %0d %h %b",
                          k, s_we, s_rd, s_addr, s_din, disp_valid, wc, 8'(8'h10 + wc), req);
        end
        if (req) begin
          total++;
          if (disp_data !== 8'h00) begin
            bad++; $display("FAIL interleave_oor k=%0d: data=%h required 00", k, disp_data);
          end
        end
        wc++;
      end
      k++;
    end
    total++;
    if (frame_done !== 1'b1 || fill_count !== 6'd16) begin
      bad++; $display("FAIL interleave_done: done=%b fill=%0d after %0d cycles required 1 16", frame_done, fill_count, k);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (mem[i] !== 8'(8'h10 + i)) begin
        bad++; $display("FAIL buffer[%0d]: got %h required %h", i, mem[i], 8'(8'h10 + i));
      end
    end
    $display("interleaved fill done in %0d cycles", k);
  endtask

  task automatic test_start_over_mid_fill();
    fq.delete();
    pulse_start_over(1);
    test_clear();
    for (int i = 0; i < DEPTH; i++) fq.push_back(8'(8'h10 + i));
    for (int i = 0; i < 7; i++) cycle(1'b0, '0);
    total++;
    if (fill_count !== 6'd7) begin
      bad++; $display("FAIL mid_fill_count: got %0d required 7", fill_count);
    end
    pulse_start_over(3);
    test_clear();
    cycle(1'b0, '0);
    total++;
    if ({s_we, s_rd, s_addr, s_din, fill_count} !== {2'b11, 5'd0, 8'h17, 6'd1}) begin
      bad++; $display("FAIL refill_start: we=%b rd=%b addr=%0d din=%h fill=%0d required 1 1 0 17 1",
                      s_we, s_rd, s_addr, s_din, fill_count);
    end
    $display("start_over mid-fill done");
  endtask

  task automatic test_rst_mid_clear();
    pulse_start_over(1);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0);
    rst = 1'b1;
    cycle(1'b0, '0);
    total++;
    if ({s_we, s_rd, s_busy} !== 3'b001) begin
      bad++; $display("FAIL rst_mid_clear: we=%b rd=%b busy=%b required 0 0 1", s_we, s_rd, s_busy);
    end
    rst = 1'b0;
    cycle(1'b0, '0);
    total++;
    if ({s_we, s_addr, s_busy} !== {1'b1, 5'd0, 1'b1}) begin
      bad++; $display("FAIL clear_restart: we=%b addr=%0d busy=%b required 1 0 1", s_we, s_addr, s_busy);
    end
    $display("rst mid-clear done");
  endtask

  initial begin
    rst = 1'b1; start_over = 1'b0; disp_req = 1'b0; disp_addr = '0;
    fifo_empty = 1'b1; fifo_dout = '0;
    for (int i = 0; i < DEPTH + 1; i++) fq.push_back(8'(8'h10 + i));
    test_reset();
    test_clear();
    test_fill();
    test_read();
    test_fill_interleaved();
    test_start_over_mid_fill();
    test_rst_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
